// File: rtl/pit_timer.sv
// ---------------------------------------------------------------------------
// pit_timer -- programmable interval timer
//
// Two chained, loadable 16-bit down counters. The prescaler decrements on
// every enabled clock. Its underflow borrows into the divider, and divider
// underflow produces a one-cycle tick and latches a sticky interrupt request.
// Software programs the block through a small register port.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   resl     asynchronous active-low reset, clears all state immediately
//   wr       register write strobe
//   addr     register select (0 PRE, 1 DIV, 2 CTL, 4 pre_cnt, 5 div_cnt)
//   din      write data
//   dout     read data, combinational from addr
//   int_ack  clears int_pend (a new event in the same cycle wins)
//   tick     registered one-cycle pulse per divider underflow
//   int_pend sticky interrupt request
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// pit_down_counter -- one loadable 16-bit down counter built from a chain of
// single-bit borrow slices.
//
// Ports:
//   clk, resl  clock and asynchronous active-low reset
//   load       software load; overrides any count or reload this cycle
//   load_val   value taken on load
//   dec        decrement point for this cycle
//   rel_val    reload value used when a decrement hits a zero count
//   cnt        current count
//   zero       count is zero, i.e. a decrement now would underflow
// ---------------------------------------------------------------------------
module pit_down_counter (
    input  logic        clk,
    input  logic        resl,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        dec,
    input  logic [15:0] rel_val,
    output logic [15:0] cnt,
    output logic        zero
);

    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;
    logic [15:0] dec_val;
    // borrow[i] is the borrow entering bit i; bit 0 always receives the
    // decrement borrow. A borrow leaving the MSB means the count was zero.
    logic [16:0] borrow;

    assign borrow[0] = 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_slice
            // Single-bit down-counter slice: the bit toggles when a borrow
            // arrives, and passes the borrow on only if it was 0.
            assign dec_val[gi]    = cnt_reg[gi] ^ borrow[gi];
            assign borrow[gi + 1] = borrow[gi] & ~cnt_reg[gi];
        end
    endgenerate

    assign zero = borrow[16];
    assign cnt  = cnt_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = load_val;
        end else if (dec) begin
            // A reload always replaces the 0 -> 0xFFFF wrap.
            cnt_next = zero ? rel_val : dec_val;
        end
    end

    always_ff @(posedge clk or negedge resl) begin
        if (!resl) begin
            cnt_reg <= 16'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

module pit_timer (
    input  logic        clk,
    input  logic        resl,
    input  logic        wr,
    input  logic [2:0]  addr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic        int_ack,
    output logic        tick,
    output logic        int_pend
);

    localparam logic [2:0] ADDR_PRE  = 3'd0;
    localparam logic [2:0] ADDR_DIV  = 3'd1;
    localparam logic [2:0] ADDR_CTL  = 3'd2;
    localparam logic [2:0] ADDR_PCNT = 3'd4;
    localparam logic [2:0] ADDR_DCNT = 3'd5;

    logic [15:0] pre_rel_reg;
    logic [15:0] div_rel_reg;
    logic        en_reg;
    logic        tick_reg;
    logic        int_pend_reg;

    logic        pre_wr;
    logic        div_wr;
    logic        ctl_wr;

    logic [15:0] pre_cnt;
    logic [15:0] div_cnt;
    logic        pre_zero;
    logic        div_zero;
    logic        pre_borrow;
    logic        div_event;

    assign pre_wr = wr && (addr == ADDR_PRE);
    assign div_wr = wr && (addr == ADDR_DIV);
    assign ctl_wr = wr && (addr == ADDR_CTL);

    // Borrow and underflow are judged on the current counts, so a software
    // load in the same cycle never hides an event: a PRE write on a borrow
    // cycle still steps the divider, and a DIV write on an underflow cycle
    // still produces the tick and interrupt.
    assign pre_borrow = en_reg & pre_zero;
    assign div_event  = pre_borrow & div_zero;

    pit_down_counter u_pre (
        .clk      (clk),
        .resl     (resl),
        .load     (pre_wr),
        .load_val (din),
        .dec      (en_reg),
        .rel_val  (pre_rel_reg),
        .cnt      (pre_cnt),
        .zero     (pre_zero)
    );

    pit_down_counter u_div (
        .clk      (clk),
        .resl     (resl),
        .load     (div_wr),
        .load_val (din),
        .dec      (pre_borrow),
        .rel_val  (div_rel_reg),
        .cnt      (div_cnt),
        .zero     (div_zero)
    );

    // Reload registers and enable.
    always_ff @(posedge clk or negedge resl) begin
        if (!resl) begin
            pre_rel_reg <= 16'd0;
            div_rel_reg <= 16'd0;
            en_reg      <= 1'b0;
        end else begin
            if (pre_wr) begin
                pre_rel_reg <= din;
            end
            if (div_wr) begin
                div_rel_reg <= din;
            end
            if (ctl_wr) begin
                en_reg <= din[0];
            end
        end
    end

    // Tick pulse and sticky interrupt; setting beats acknowledging so an
    // event coinciding with int_ack is not lost.
    always_ff @(posedge clk or negedge resl) begin
        if (!resl) begin
            tick_reg     <= 1'b0;
            int_pend_reg <= 1'b0;
        end else begin
            tick_reg <= div_event;
            if (div_event) begin
                int_pend_reg <= 1'b1;
            end else if (int_ack) begin
                int_pend_reg <= 1'b0;
            end
        end
    end

    assign tick     = tick_reg;
    assign int_pend = int_pend_reg;

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        dout = 16'd0;
        case (addr)
            ADDR_PRE:  dout = pre_rel_reg;
            ADDR_DIV:  dout = div_rel_reg;
            ADDR_CTL:  dout = {14'd0, int_pend_reg, en_reg};
            ADDR_PCNT: dout = pre_cnt;
            ADDR_DCNT: dout = div_cnt;
            default:   dout = 16'd0;
        endcase
    end

endmodule
